// File: rtl/dram_pkg.sv
// Shared types and helpers for the 68040 DRAM controller.
// Provides the FSM state enum, SIZ encodings, and the byte-lane CAS decode.
// Also provides the row/column split of the CPU address onto the 11-bit MA bus.
package dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RCD,
    ST_CAS,
    ST_CPRE,
    ST_RCAS,
    ST_RRAS,
    ST_PRE
  } state_e;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  // Width of the shared per-state cycle counter.
  localparam int CNT_W = 8;

  // CAS3 drives D31:24, so byte offset 0 maps to the top lane.
  function automatic logic [3:0] lane_cas(input logic [1:0] a, input logic [1:0] siz);
    logic [3:0] c;
    c = 4'b1111;
    case (siz)
      SIZ_BYTE:           c = 4'b1000 >> a;
      SIZ_WORD:           c = a[1] ? 4'b0011 : 4'b1100;
      SIZ_LONG, SIZ_LINE: c = 4'b1111;
      default:            c = 4'b1111;
    endcase
    return c;
  endfunction

  function automatic logic [10:0] row_of(input logic [23:0] a);
    return a[23:13];
  endfunction

  function automatic logic [10:0] col_of(input logic [23:0] a);
    return a[12:2];
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh request generator: free-running down-counter with a single pending flag.
// Latency: ref_pend_o rises on the edge where the counter is at zero; clears on ref_ack_i.
// Backpressure: an expiry while a refresh is already owed is absorbed (only one is owed).
// Ports: clk_i, rst_ni (async active-low), ref_ack_i (one-cycle ack), ref_pend_o.
module dram_refresh_timer #(
  parameter int REFRESH_PERIOD = 390
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ref_ack_i,
  output logic ref_pend_o
);

  localparam int CW = $clog2(REFRESH_PERIOD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          expire;

  always_comb begin
    expire = (cnt_q == '0);
    cnt_d  = expire ? RELOAD : (cnt_q - CW'(1));
    // A fresh expiry coinciding with an ack still leaves one refresh owed.
    pend_d = expire | (pend_q & ~ref_ack_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pend_o = pend_q;

endmodule

// File: rtl/dram_ctrl.sv
// 68040 bus-side DRAM controller: RAS/CAS sequencing, row/col mux, nWE, nTA, CBR refresh.
// Latency: first strobe one BCLK after the nTS sample edge; nTA on last CAS cycle of each beat.
// Backpressure: none toward the CPU; refresh waits for IDLE and wins ties with a new access.
// Ports: BCLK, nRESET (async active-low), nTS/dramsel/A/SIZ/RW from the CPU bus;
//        MA, RAS, CAS, nWE, nTA to the SIMM array / CPU, all driven straight from flops.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int TRCD_CYC       = 2,
  parameter int TCAS_CYC       = 2,
  parameter int TRP_CYC        = 2,
  parameter int REFRESH_PERIOD = 390
) (
  input  logic        BCLK,
  input  logic        nRESET,
  input  logic        nTS,
  input  logic        dramsel,
  input  logic [23:0] A,
  input  logic [1:0]  SIZ,
  input  logic        RW,
  output logic [10:0] MA,
  output logic [3:0]  RAS,
  output logic [3:0]  CAS,
  output logic        nWE,
  output logic        nTA
);

  localparam logic [CNT_W-1:0] RCD_LAST  = CNT_W'(TRCD_CYC - 1);
  localparam logic [CNT_W-1:0] CAS_LAST  = CNT_W'(TCAS_CYC - 1);
  localparam logic [CNT_W-1:0] RRAS_LAST = CNT_W'(TRCD_CYC + TCAS_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(TRP_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       beat_q, beat_d;
  logic             acc_pend_q, acc_pend_d;
  logic [23:0]      addr_q, addr_d;
  logic [1:0]       siz_q, siz_d;
  logic             rw_q, rw_d;

  logic [10:0]      ma_q, ma_d;
  logic [3:0]       ras_q, ras_d;
  logic [3:0]       cas_q, cas_d;
  logic             nwe_q, nwe_d;
  logic             nta_q, nta_d;

  logic             capture;
  logic             ref_pend;
  logic             ref_ack;
  logic             beat_adv;

  dram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_refresh (
    .clk_i     (BCLK),
    .rst_ni    (nRESET),
    .ref_ack_i (ref_ack),
    .ref_pend_o(ref_pend)
  );

  assign capture = ~nTS & dramsel;
  assign ref_ack = (state_q == ST_RCAS);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ref_pend)        state_d = ST_RCAS;
        else if (acc_pend_q) state_d = ST_RCD;
      end
      ST_RCD:  if (cnt_q == RCD_LAST) state_d = ST_CAS;
      ST_CAS: begin
        if (cnt_q == CAS_LAST)
          state_d = (siz_q == SIZ_LINE && beat_q != 2'd3) ? ST_CPRE : ST_PRE;
      end
      ST_CPRE: state_d = ST_CAS;
      ST_RCAS: state_d = ST_RRAS;
      ST_RRAS: if (cnt_q == RRAS_LAST) state_d = ST_PRE;
      ST_PRE:  if (cnt_q == PRE_LAST)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: cycle counter, beat counter, latched request.
  always_comb begin
    beat_adv   = (state_q == ST_CAS) && (state_d == ST_CPRE);
    cnt_d      = (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
    beat_d     = beat_q;
    if (state_q == ST_IDLE && state_d == ST_RCD) beat_d = 2'd0;
    else if (beat_adv)                           beat_d = beat_q + 2'd1;

    addr_d     = addr_q;
    siz_d      = siz_q;
    rw_d       = rw_q;
    acc_pend_d = acc_pend_q;
    if (capture) begin
      addr_d     = A;
      siz_d      = SIZ;
      rw_d       = RW;
      acc_pend_d = 1'b1;
    end else begin
      // Line bursts walk A[3:2] modulo 4 starting from the critical longword.
      if (beat_adv) addr_d = {addr_q[23:4], addr_q[3:2] + 2'd1, addr_q[1:0]};
      // Only an access leaving CAS retires the request; refresh precharge must not.
      if (state_q == ST_CAS && state_d == ST_PRE) acc_pend_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state and registered, so every pin is a flop.
  always_comb begin
    ras_d = 4'b0000;
    cas_d = 4'b0000;
    nwe_d = 1'b1;
    nta_d = 1'b1;
    ma_d  = row_of(addr_d);
    case (state_d)
      ST_RCD: begin
        ras_d = 4'b1111;
        nwe_d = rw_d;
      end
      ST_CAS: begin
        ras_d = 4'b1111;
        cas_d = lane_cas(addr_d[1:0], siz_d);
        ma_d  = col_of(addr_d);
        nwe_d = rw_d;
        nta_d = (cnt_d != CAS_LAST);
      end
      ST_CPRE: begin
        ras_d = 4'b1111;
        ma_d  = col_of(addr_d);
        nwe_d = rw_d;
      end
      ST_RCAS: cas_d = 4'b1111;
      ST_RRAS: begin
        ras_d = 4'b1111;
        cas_d = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge BCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beat_q     <= 2'd0;
      acc_pend_q <= 1'b0;
      addr_q     <= '0;
      siz_q      <= SIZ_LONG;
      rw_q       <= 1'b1;
      ma_q       <= '0;
      ras_q      <= 4'b0000;
      cas_q      <= 4'b0000;
      nwe_q      <= 1'b1;
      nta_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      acc_pend_q <= acc_pend_d;
      addr_q     <= addr_d;
      siz_q      <= siz_d;
      rw_q       <= rw_d;
      ma_q       <= ma_d;
      ras_q      <= ras_d;
      cas_q      <= cas_d;
      nwe_q      <= nwe_d;
      nta_q      <= nta_d;
    end
  end

  assign MA  = ma_q;
  assign RAS = ras_q;
  assign CAS = cas_q;
  assign nWE = nwe_q;
  assign nTA = nta_q;

endmodule
